fc_enum_ctrl: RTL and testbench

Sequencer for the Crypto-1 non-linear filter function Fc (5 inputs, truth table `FN`, output `FN[x]`). It accepts a request carrying one observed keystream bit. It then streams, in ascending order, every 5-bit input `x` with `FN[x] == bit`, one candidate per cycle under valid/ready backpressure, and reports completion with a match count. It sits between the keystream-bit source and the state-recovery search that consumes candidate Fc input tuples.

---
 rtl/fc_enum_pkg.sv | 21 ++
 rtl/fc_ffs32.sv | 36 +++
 rtl/fc_enum_ctrl.sv | 126 ++++++++++++
 tb/tb_fc_enum_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_enum_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fc_enum_pkg
// Brief    : Shared constants and types for the Crypto-1 Fc candidate sequencer.
// Revision : 1.0
// ============================================================================
package fc_enum_pkg;

    localparam int FC_IN_W  = 5;
    localparam int FC_CNT_W = 6;

    // Fc truth table: bit x is the filter output for 5-bit input x.
    localparam logic [31:0] FC_FN = 32'hEC57E80A;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } fc_enum_state_t;

endpackage : fc_enum_pkg
`default_nettype wire

// File: rtl/fc_ffs32.sv
`default_nettype none
// ============================================================================
// Module   : fc_ffs32
// Brief    : Combinational find-first-set at or above a start index, with a
//            flag telling whether another set bit lies above the result.
// Revision : 1.0
// ============================================================================
module fc_ffs32
    import fc_enum_pkg::*;
(
    input  logic [31:0]        vec,
    input  logic [FC_IN_W-1:0] start,
    output logic               found,
    output logic [FC_IN_W-1:0] idx,
    output logic               more
);

    logic [31:0] w_masked;
    logic [31:0] w_above;

    always_comb begin
        w_masked = vec & ~((32'h1 << start) - 32'h1);
        found    = |w_masked;
        idx      = '0;
        for (int i = 31; i >= 0; i--) begin
            if (w_masked[i]) begin
                idx = FC_IN_W'(i);
            end
        end
        // For idx==31 the shift wraps to zero and the mask collapses to zero.
        w_above = w_masked & ~((32'h2 << idx) - 32'h1);
        more    = |w_above;
    end

endmodule : fc_ffs32
`default_nettype wire

// File: rtl/fc_enum_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fc_enum_ctrl
// Brief    : Streams every Fc input x with FN[x]==REQ_BIT in ascending order
//            under valid/ready, then pulses DONE with the match count.
// Revision : 1.0
// ============================================================================
module fc_enum_ctrl
    import fc_enum_pkg::*;
#(
    parameter logic [31:0] FN = FC_FN
) (
    input  logic                CLK,
    input  logic                RESETn,
    input  logic                REQ_VALID,
    output logic                REQ_READY,
    input  logic                REQ_BIT,
    input  logic                ABORT,
    output logic                CAND_VALID,
    input  logic                CAND_READY,
    output logic [FC_IN_W-1:0]  CAND,
    output logic [FC_IN_W-1:0]  CAND_IDX,
    output logic                CAND_LAST,
    output logic                DONE,
    output logic [FC_CNT_W-1:0] COUNT,
    output logic                BUSY
);

    fc_enum_state_t        r_state;
    logic [31:0]           r_mask;
    logic [FC_IN_W-1:0]    r_cand;
    logic [FC_IN_W-1:0]    r_idx;
    logic                  r_last;
    logic                  r_done;
    logic [FC_CNT_W-1:0]   r_count;

    logic [31:0]           w_req_mask;
    logic                  w_first_found;
    logic [FC_IN_W-1:0]    w_first_idx;
    logic                  w_first_more;
    logic                  w_next_found;
    logic [FC_IN_W-1:0]    w_next_idx;
    logic                  w_next_more;
    logic [FC_IN_W-1:0]    w_next_start;
    logic                  w_handshake;

    assign w_req_mask   = REQ_BIT ? FN : ~FN;
    // Only consulted while CAND_LAST is low, so r_cand < 31 and this never wraps.
    assign w_next_start = r_cand + FC_IN_W'(1);

    fc_ffs32 u_ffs_first (
        .vec   (w_req_mask),
        .start ('0),
        .found (w_first_found),
        .idx   (w_first_idx),
        .more  (w_first_more)
    );

    fc_ffs32 u_ffs_next (
        .vec   (r_mask),
        .start (w_next_start),
        .found (w_next_found),
        .idx   (w_next_idx),
        .more  (w_next_more)
    );

    assign REQ_READY   = (r_state == IDLE);
    assign BUSY        = !REQ_READY;
    assign CAND_VALID  = (r_state == EMIT);
    assign w_handshake = CAND_VALID && CAND_READY;

    assign CAND      = r_cand;
    assign CAND_IDX  = r_idx;
    assign CAND_LAST = r_last;
    assign DONE      = r_done;
    assign COUNT     = r_count;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_state <= IDLE;
            r_mask  <= '0;
            r_cand  <= '0;
            r_idx   <= '0;
            r_last  <= 1'b0;
            r_done  <= 1'b0;
            r_count <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (REQ_VALID) begin
                        r_mask <= w_req_mask;
                        if (!w_first_found) begin
                            r_done  <= 1'b1;
                            r_count <= '0;
                        end else begin
                            r_cand  <= w_first_idx;
                            r_idx   <= '0;
                            r_last  <= !w_first_more;
                            r_state <= EMIT;
                        end
                    end
                end
                EMIT: begin
                    // ABORT wins over completion: the sweep ends silently.
                    if (ABORT) begin
                        r_state <= IDLE;
                    end else if (w_handshake) begin
                        if (r_last) begin
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                            r_count <= FC_CNT_W'(r_idx) + FC_CNT_W'(1);
                        end else if (w_next_found) begin
                            r_cand <= w_next_idx;
                            r_idx  <= r_idx + FC_IN_W'(1);
                            r_last <= !w_next_more;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule : fc_enum_ctrl
`default_nettype wire

// File: tb/tb_fc_enum_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fc_enum_ctrl
// Brief    : Self-checking bench for fc_enum_ctrl against a truth-table model.
// Revision : 1.0
// ============================================================================
module tb_fc_enum_ctrl;

    logic       clk;
    logic       rst_n;
    logic [2:0] req_valid;
    logic       req_bit;
    logic       abort;
    logic       cand_ready;
    int         sel;
    int         compared;
    int         mismatched;
    int         exp_count [3];

    logic       rr [3], cv [3], cl [3], dn [3], bz [3];
    logic [4:0] cd [3], ci [3];
    logic [5:0] ct [3];

    logic       m_rr, m_cv, m_cl, m_dn, m_bz;
    logic [4:0] m_cd, m_ci;
    logic [5:0] m_ct;

    fc_enum_ctrl u_dut (
        .CLK(clk), .RESETn(rst_n), .REQ_VALID(req_valid[0]), .REQ_READY(rr[0]),
        .REQ_BIT(req_bit), .ABORT(abort), .CAND_VALID(cv[0]), .CAND_READY(cand_ready),
        .CAND(cd[0]), .CAND_IDX(ci[0]), .CAND_LAST(cl[0]), .DONE(dn[0]),
        .COUNT(ct[0]), .BUSY(bz[0])
    );

    fc_enum_ctrl #(.FN(32'h0000_0000)) u_zero (
        .CLK(clk), .RESETn(rst_n), .REQ_VALID(req_valid[1]), .REQ_READY(rr[1]),
        .REQ_BIT(req_bit), .ABORT(abort), .CAND_VALID(cv[1]), .CAND_READY(cand_ready),
        .CAND(cd[1]), .CAND_IDX(ci[1]), .CAND_LAST(cl[1]), .DONE(dn[1]),
        .COUNT(ct[1]), .BUSY(bz[1])
    );

    fc_enum_ctrl #(.FN(32'hFFFF_FFFF)) u_ones (
        .CLK(clk), .RESETn(rst_n), .REQ_VALID(req_valid[2]), .REQ_READY(rr[2]),
        .REQ_BIT(req_bit), .ABORT(abort), .CAND_VALID(cv[2]), .CAND_READY(cand_ready),
        .CAND(cd[2]), .CAND_IDX(ci[2]), .CAND_LAST(cl[2]), .DONE(dn[2]),
        .COUNT(ct[2]), .BUSY(bz[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        m_rr = rr[0]; m_cv = cv[0]; m_cl = cl[0]; m_dn = dn[0]; m_bz = bz[0];
        m_cd = cd[0]; m_ci = ci[0]; m_ct = ct[0];
        if (sel == 1) begin
            m_rr = rr[1]; m_cv = cv[1]; m_cl = cl[1]; m_dn = dn[1]; m_bz = bz[1];
            m_cd = cd[1]; m_ci = ci[1]; m_ct = ct[1];
        end else if (sel == 2) begin
            m_rr = rr[2]; m_cv = cv[2]; m_cl = cl[2]; m_dn = dn[2]; m_bz = bz[2];
            m_cd = cd[2]; m_ci = ci[2]; m_ct = ct[2];
        end
    end

    function automatic logic [31:0] fn_of(input int s);
        logic [31:0] f;
        f = 32'hEC57E80A;
        if (s == 1) f = 32'h0;
        if (s == 2) f = 32'hFFFF_FFFF;
        return f;
    endfunction

    // {REQ_READY, CAND_VALID, CAND, CAND_IDX, CAND_LAST, DONE, COUNT, BUSY}
    function automatic logic [20:0] snap();
        return {m_rr, m_cv, m_cd, m_ci, m_cl, m_dn, m_ct, m_bz};
    endfunction

    // Caller is parked at a negedge; the request is presented right away.
    task automatic run_sweep(input int s, input bit b, input int stall_pct,
                             input int abort_at, input string tag);
        logic [31:0] fn;
        int          q[$];
        int          k;
        int          cyc;
        logic [13:0] got, want;
        fn = fn_of(s);
        for (int x = 0; x < 32; x++) if (fn[x] == b) q.push_back(x);
        sel = s;
        #1;
        compared++;
        if (m_rr !== 1'b1) begin
            mismatched++;
            $display("FAIL %s req_ready: got %b want 1", tag, m_rr);
        end
        req_valid[s] = 1'b1; req_bit = b; cand_ready = 1'b0; abort = 1'b0;
        @(negedge clk);
        req_valid = '0;
        if (q.size() == 0) begin
            compared++;
            if ({m_cv, m_dn, m_ct} !== {1'b0, 1'b1, 6'd0}) begin
                mismatched++;
                $display("FAIL %s empty_done: got v=%b d=%b c=%0d want v=0 d=1 c=0",
                         tag, m_cv, m_dn, m_ct);
            end
            exp_count[s] = 0;
            @(negedge clk);
            compared++;
            if ({m_cv, m_dn, m_rr} !== 3'b001) begin
                mismatched++;
                $display("FAIL %s empty_after: got v=%b d=%b rr=%b want 0 0 1",
                         tag, m_cv, m_dn, m_rr);
            end
            return;
        end
        k = 0; cyc = 0;
        while (k < q.size() && cyc < 400) begin
            cyc++;
            got  = {m_cv, m_cd, m_ci, m_cl, m_dn, m_bz};
            want = {1'b1, 5'(q[k]), 5'(k), (k == q.size() - 1), 1'b0, 1'b1};
            compared++;
            if (got !== want) begin
                mismatched++;
                $display("FAIL %s cand[%0d]: got v=%b x=%0d i=%0d l=%b d=%b bz=%b want x=%0d i=%0d l=%b",
                         tag, k, m_cv, m_cd, m_ci, m_cl, m_dn, m_bz, q[k], k, (k == q.size() - 1));
            end
            if (k == abort_at) begin
                cand_ready = 1'b1; abort = 1'b1;
                @(negedge clk);
                abort = 1'b0; cand_ready = 1'b0;
                compared++;
                if ({m_cv, m_dn, m_rr, m_ct} !== {3'b001, 6'(exp_count[s])}) begin
                    mismatched++;
                    $display("FAIL %s abort: got v=%b d=%b rr=%b c=%0d want 0 0 1 c=%0d",
                             tag, m_cv, m_dn, m_rr, m_ct, exp_count[s]);
                end
                return;
            end
            cand_ready = ($urandom_range(99) >= stall_pct);
            @(negedge clk);
            if (cand_ready) k++;
        end
        cand_ready = 1'b0;
        if (k < q.size()) begin
            compared++;
            mismatched++;
            $display("FAIL %s timeout: got %0d candidates want %0d", tag, k, q.size());
        end
        compared++;
        if ({m_cv, m_dn, m_rr, m_ct} !== {3'b011, 6'(q.size())}) begin
            mismatched++;
            $display("FAIL %s done: got v=%b d=%b rr=%b c=%0d want 0 1 1 c=%0d",
                     tag, m_cv, m_dn, m_rr, m_ct, q.size());
        end
        exp_count[s] = q.size();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = '0; req_bit = 1'b0; abort = 1'b0; cand_ready = 1'b0;
        sel = 0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            compared++;
            if (snap() !== {2'b10, 19'd0}) begin
                mismatched++;
                $display("FAIL reset[%0d]: got %h want %h", s, snap(), {2'b10, 19'd0});
            end
        end
        rst_n = 1'b1;
        exp_count = '{0, 0, 0};
        @(negedge clk);
    endtask

    task automatic test_bit1();    run_sweep(0, 1'b1, 0, -1, "bit1");       endtask
    task automatic test_bit0();    run_sweep(0, 1'b0, 0, -1, "bit0");       endtask

    task automatic test_stalls();
        run_sweep(0, 1'b1, 50, -1, "stall1");
        run_sweep(0, 1'b0, 60, -1, "stall0");
    endtask

    task automatic test_abort();
        run_sweep(0, 1'b1, 0, 4, "abort");
        run_sweep(0, 1'b0, 30, -1, "after_abort");
    endtask

    task automatic test_abort_idle();
        sel = 0;
        abort = 1'b1; req_valid[0] = 1'b1; req_bit = 1'b1; cand_ready = 1'b0;
        @(negedge clk);
        req_valid = '0;
        compared++;
        if ({m_cv, m_cd, m_ci, m_bz} !== {1'b1, 5'd1, 5'd0, 1'b1}) begin
            mismatched++;
            $display("FAIL abort_idle_accept: got v=%b x=%0d i=%0d bz=%b want 1 1 0 1",
                     m_cv, m_cd, m_ci, m_bz);
        end
        @(negedge clk);
        abort = 1'b0;
        compared++;
        if ({m_cv, m_dn, m_rr} !== 3'b001) begin
            mismatched++;
            $display("FAIL abort_emit: got v=%b d=%b rr=%b want 0 0 1", m_cv, m_dn, m_rr);
        end
    endtask

    task automatic test_fn_extremes();
        run_sweep(1, 1'b1, 0, -1, "fn0_b1");
        run_sweep(1, 1'b0, 20, -1, "fn0_b0");
        run_sweep(2, 1'b1, 0, -1, "fn1_b1");
        run_sweep(2, 1'b0, 0, -1, "fn1_b0");
    endtask

    task automatic test_reset_mid();
        sel = 0;
        req_valid[0] = 1'b1; req_bit = 1'b1; cand_ready = 1'b1;
        @(negedge clk);
        req_valid = '0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if (snap() !== {2'b10, 19'd0}) begin
            mismatched++;
            $display("FAIL reset_mid: got %h want %h", snap(), {2'b10, 19'd0});
        end
        cand_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_count = '{0, 0, 0};
        run_sweep(0, 1'b1, 25, -1, "after_reset");
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        test_reset();
        test_bit1();
        test_bit0();
        test_stalls();
        test_abort();
        test_abort_idle();
        test_fn_extremes();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_fc_enum_ctrl
`default_nettype wire
